// File: rtl/tile_scheduler_pkg.sv
// tile_scheduler_pkg: shared types and sizing for the matmul tile scheduler
package tile_scheduler_pkg;
   localparam int TILE_DIM   = 32;
   localparam int ACC_ADDR_W = 7;
   localparam int CNT_W      = 4;
   localparam int WIDX_W     = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ADVANCE} sched_state_e;

   typedef struct packed {
      logic [CNT_W-1:0]      k_tiles;
      logic [CNT_W-1:0]      n_tiles;
      logic [ACC_ADDR_W-1:0] acc_base;
   } tile_cmd_t;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: k/n tile counters with registered weight/activation/accumulator addressing
module tile_addr_gen
   import tile_scheduler_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  step_i,
   input  tile_cmd_t             cmd_i,
   output logic [WIDX_W-1:0]     weight_idx_o,
   output logic [CNT_W-1:0]      act_idx_o,
   output logic [ACC_ADDR_W-1:0] acc_addr_o,
   output logic                  acc_accumulate_o,
   output logic                  last_o
);
   tile_cmd_t        cmd_q;
   logic [CNT_W-1:0] n_q;
   logic             k_wrap;

   assign k_wrap = act_idx_o == cmd_q.k_tiles;
   assign last_o = k_wrap && (n_q == cmd_q.n_tiles);

   // n*(K+1)+k advances by exactly one per tile, so the weight index is a plain counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cmd_q            <= '0;
         n_q              <= '0;
         act_idx_o        <= '0;
         weight_idx_o     <= '0;
         acc_addr_o       <= '0;
         acc_accumulate_o <= 1'b0;
      end else if (load_i) begin
         cmd_q            <= cmd_i;
         n_q              <= '0;
         act_idx_o        <= '0;
         weight_idx_o     <= '0;
         acc_addr_o       <= cmd_i.acc_base;
         acc_accumulate_o <= 1'b0;
      end else if (step_i) begin
         n_q              <= k_wrap ? n_q + 1'b1 : n_q;
         act_idx_o        <= k_wrap ? '0 : act_idx_o + 1'b1;
         weight_idx_o     <= weight_idx_o + 1'b1;
         acc_addr_o       <= k_wrap ? acc_addr_o + ACC_ADDR_W'(TILE_DIM) : acc_addr_o;
         acc_accumulate_o <= !k_wrap;
      end
   end
endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks N x K weight tiles of one matmul command, one control_unit op per tile
module tile_scheduler
   import tile_scheduler_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [CNT_W-1:0]      cmd_k_tiles_i,
   input  logic [CNT_W-1:0]      cmd_n_tiles_i,
   input  logic [ACC_ADDR_W-1:0] cmd_acc_base_i,
   output logic                  tile_start_o,
   output logic [WIDX_W-1:0]     weight_idx_o,
   output logic [CNT_W-1:0]      act_idx_o,
   output logic [ACC_ADDR_W-1:0] acc_addr_o,
   output logic                  acc_accumulate_o,
   input  logic                  tile_done_i,
   output logic                  busy_o,
   output logic                  cmd_done_o,
   output logic [15:0]           tiles_issued_o
);
   sched_state_e state;
   tile_cmd_t    cmd;
   logic         load, step, last;

   assign cmd  = '{k_tiles: cmd_k_tiles_i, n_tiles: cmd_n_tiles_i, acc_base: cmd_acc_base_i};
   assign load = (state == IDLE) && cmd_valid_i;
   assign step = (state == ADVANCE) && !last;

   tile_addr_gen u_addr (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .load_i           (load),
      .step_i           (step),
      .cmd_i            (cmd),
      .weight_idx_o     (weight_idx_o),
      .act_idx_o        (act_idx_o),
      .acc_addr_o       (acc_addr_o),
      .acc_accumulate_o (acc_accumulate_o),
      .last_o           (last)
   );

   // cmd_done is raised on entry to ADVANCE so it trails the last tile_done by one cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         cmd_ready_o    <= 1'b1;
         tile_start_o   <= 1'b0;
         busy_o         <= 1'b0;
         cmd_done_o     <= 1'b0;
         tiles_issued_o <= '0;
      end else begin
         tile_start_o <= 1'b0;
         cmd_done_o   <= 1'b0;
         case (state)
            IDLE: if (cmd_valid_i) begin
               state        <= ISSUE;
               cmd_ready_o  <= 1'b0;
               busy_o       <= 1'b1;
               tile_start_o <= 1'b1;
            end
            ISSUE: begin
               state          <= WAIT_DONE;
               tiles_issued_o <= tiles_issued_o + 16'(tiles_issued_o != 16'hFFFF);
            end
            WAIT_DONE: if (tile_done_i) begin
               state      <= ADVANCE;
               cmd_done_o <= last;
               busy_o     <= !last;
            end
            ADVANCE: begin
               state        <= last ? IDLE : ISSUE;
               cmd_ready_o  <= last;
               tile_start_o <= !last;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: randomized commands checked against a formula-based tile sequence model
module tb_tile_scheduler;
   logic        clk_i = 1'b0, rst_i = 1'b1, cmd_valid_i = 1'b0, tile_done_i = 1'b0;
   logic [3:0]  cmd_k_tiles_i = '0, cmd_n_tiles_i = '0;
   logic [6:0]  cmd_acc_base_i = '0;
   logic        cmd_ready_o, tile_start_o, acc_accumulate_o, busy_o, cmd_done_o;
   logic [7:0]  weight_idx_o;
   logic [3:0]  act_idx_o;
   logic [6:0]  acc_addr_o;
   logic [15:0] tiles_issued_o;
   int checks = 0, errors = 0, total = 0;

   tile_scheduler dut (
      .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_k_tiles_i(cmd_k_tiles_i), .cmd_n_tiles_i(cmd_n_tiles_i), .cmd_acc_base_i(cmd_acc_base_i),
      .tile_start_o(tile_start_o), .weight_idx_o(weight_idx_o), .act_idx_o(act_idx_o),
      .acc_addr_o(acc_addr_o), .acc_accumulate_o(acc_accumulate_o), .tile_done_i(tile_done_i),
      .busy_o(busy_o), .cmd_done_o(cmd_done_o), .tiles_issued_o(tiles_issued_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, cmd_ready_o, 1);
      chk({tag, "_start"}, tile_start_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, cmd_done_o, 0);
      chk({tag, "_accum"}, acc_accumulate_o, 0);
      chk({tag, "_w"}, weight_idx_o, 0);
      chk({tag, "_a"}, act_idx_o, 0);
      chk({tag, "_acc"}, acc_addr_o, 0);
      chk({tag, "_cnt"}, tiles_issued_o, 0);
   endtask

   // Issue one command at a negedge in IDLE and play control_unit for every expected tile
   task automatic run_cmd(input int kmax, input int nmax, input int base, input int dly,
                          input bit noise, input int abort_at);
      int t = 0;
      int last_t = (kmax + 1) * (nmax + 1) - 1;
      chk("ready", cmd_ready_o, 1);
      if (noise) begin
         tile_done_i = 1'b1;
         @(posedge clk_i); #1 tile_done_i = 1'b0;
         @(negedge clk_i);
         chk("idle_done_ign", tile_start_o, 0);
         chk("idle_cnt", tiles_issued_o, total);
      end
      cmd_valid_i = 1'b1;
      cmd_k_tiles_i = 4'(kmax);
      cmd_n_tiles_i = 4'(nmax);
      cmd_acc_base_i = 7'(base);
      @(posedge clk_i); #1;
      if (noise) begin
         cmd_k_tiles_i = 4'($urandom);
         cmd_n_tiles_i = 4'($urandom);
         cmd_acc_base_i = 7'($urandom);
      end else cmd_valid_i = 1'b0;
      @(negedge clk_i);
      chk("start_lat", tile_start_o, 1);
      for (int n = 0; n <= nmax; n++) begin
         for (int k = 0; k <= kmax; k++) begin
            chk("weight", weight_idx_o, n * (kmax + 1) + k);
            chk("act", act_idx_o, k);
            chk("acc", acc_addr_o, (base + n * 32) % 128);
            chk("accum", acc_accumulate_o, k != 0);
            chk("busy", busy_o, 1);
            chk("ready_busy", cmd_ready_o, 0);
            if (t == abort_at) begin
               @(posedge clk_i); #1 rst_i = 1'b1;
               #1 chk_reset_vals("abort");
               total = 0;
               repeat (2) begin
                  @(negedge clk_i);
                  chk("abort_no_done", cmd_done_o, 0);
               end
               @(posedge clk_i); #1 rst_i = 1'b0;
               cmd_valid_i = 1'b0;
               @(negedge clk_i);
               return;
            end
            if (noise) tile_done_i = 1'b1;
            @(posedge clk_i); #1 tile_done_i = 1'b0;
            for (int i = 0; i < dly; i++) begin
               @(posedge clk_i); #1;
            end
            if (t == last_t) cmd_valid_i = 1'b0;
            tile_done_i = 1'b1;
            @(posedge clk_i); #1 tile_done_i = 1'b0;
            @(negedge clk_i);
            chk("cmd_done", cmd_done_o, t == last_t);
            chk("adv_start", tile_start_o, 0);
            @(negedge clk_i);
            if (t == last_t) begin
               chk("done_pulse", cmd_done_o, 0);
               chk("ready_after", cmd_ready_o, 1);
               chk("busy_end", busy_o, 0);
            end else chk("gap", tile_start_o, 1);
            t++;
         end
      end
      total += last_t + 1;
      chk("count", tiles_issued_o, total);
   endtask

   initial begin
      @(negedge clk_i);
      chk_reset_vals("reset");
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      run_cmd(0, 0, 5, 1, 1'b0, -1);
      run_cmd(2, 1, 0, 2, 1'b0, -1);
      run_cmd(0, 3, 100, 0, 1'b0, -1);
      run_cmd(1, 1, 17, 1, 1'b1, -1);
      run_cmd(2, 1, 9, 1, 1'b0, 2);
      chk("post_abort_cnt", tiles_issued_o, 0);
      run_cmd(1, 2, 50, 0, 1'b0, -1);
      for (int r = 0; r < 8; r++)
         run_cmd(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      run_cmd(15, 15, 127, 0, 1'b0, -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
